// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding, constants and width helper for the 1x3 row engine
package conv_pkg;

    localparam int NUM_TAPS   = 3;
    localparam int FLUSH_POPS = NUM_TAPS - 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    // Product grows by 2*dat_width+1, a 3-tap sum by 2 more, plus channel accumulation.
    function automatic int min_acc_width(input int dat_width, input int num_ch);
        return 2 * dat_width + 3 + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/mac3.sv
// rtl/mac3.sv - 3-tap unsigned pixel x signed weight multiply stage plus registered adder tree (2 cycles)
module mac3
    import conv_pkg::*;
#(
    parameter int DAT_WIDTH = 8,
    parameter int SUM_WIDTH = 2 * DAT_WIDTH + 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_val,
    input  logic [NUM_TAPS*DAT_WIDTH-1:0]   pix,
    input  logic [NUM_TAPS*DAT_WIDTH-1:0]   wgt,
    output logic                            out_val,
    output logic signed [SUM_WIDTH-1:0]     out_sum,
    output logic                            pipe_busy
);

    localparam int PW = 2 * DAT_WIDTH + 1;

    logic signed [PW-1:0]        prod [NUM_TAPS];
    logic                        prod_val;
    logic signed [SUM_WIDTH-1:0] tree_sum;

    // Pixels are zero-extended by one bit so the multiply stays signed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_val <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                prod[k] <= '0;
            end
        end else begin
            prod_val <= in_val;
            if (in_val) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    prod[k] <= PW'($signed({1'b0, pix[k*DAT_WIDTH +: DAT_WIDTH]}))
                             * PW'($signed(wgt[k*DAT_WIDTH +: DAT_WIDTH]));
                end
            end
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            tree_sum = tree_sum + SUM_WIDTH'(prod[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val <= 1'b0;
            out_sum <= '0;
        end else begin
            out_val <= prod_val;
            if (prod_val) begin
                out_sum <= tree_sum;
            end
        end
    end

    assign pipe_busy = prod_val | out_val;

endmodule

// File: rtl/conv1x3_row_engine.sv
// rtl/conv1x3_row_engine.sv - 1x3 convolution over NUM_CH channel rows from a 3-wide FIFO; CONV1X3_RELU_EN clamps negative outputs to 0
module conv1x3_row_engine
    import conv_pkg::*;
#(
    parameter int DAT_WIDTH     = 8,
    parameter int NUM_RDATA     = 3,
    parameter int FF_ADDR_WIDTH = 3,
    parameter int ROW_LEN       = 8,
    parameter int NUM_CH        = 4,
    parameter int ACC_WIDTH     = 21
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         wgt_wr,
    input  logic [1:0]                   wgt_idx,
    input  logic [DAT_WIDTH-1:0]         wgt_data,
    input  logic [FF_ADDR_WIDTH:0]       ff_data_counter,
    output logic                         ff_rd_req,
    input  logic [DAT_WIDTH*3-1:0]       ff_rd_data,
    input  logic                         ff_rd_data_val,
    output logic [ACC_WIDTH-1:0]         out_data,
    output logic                         out_val,
    output logic                         busy,
    output logic                         done
);

    localparam int SUM_W = 2 * DAT_WIDTH + 3;
    localparam int NWIN  = ROW_LEN - 2;
    localparam int POS_W = $clog2(ROW_LEN);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FL_W  = $clog2(FLUSH_POPS + 1);

    localparam logic [POS_W-1:0]       POS_LAST = POS_W'(NWIN - 1);
    localparam logic [CH_W-1:0]        CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [FL_W-1:0]        FL_LAST  = FL_W'(FLUSH_POPS - 1);
    localparam logic [FF_ADDR_WIDTH:0] CNT_WIN  = (FF_ADDR_WIDTH + 1)'(NUM_TAPS);
    localparam logic [FF_ADDR_WIDTH:0] CNT_ONE  = (FF_ADDR_WIDTH + 1)'(1);

    if (ACC_WIDTH < min_acc_width(DAT_WIDTH, NUM_CH) || NUM_RDATA != NUM_TAPS
        || ROW_LEN < 3 || NUM_CH < 1) begin : g_param_err
        $error("conv1x3_row_engine: illegal parameter combination");
    end

    state_t                 state;
    logic [CH_W-1:0]        ch_cnt;
    logic [POS_W-1:0]       pos_cnt;
    logic [FL_W-1:0]        fl_cnt;
    logic [DAT_WIDTH-1:0]   wgt [NUM_TAPS];
    logic [NUM_TAPS*DAT_WIDTH-1:0] wgt_flat;

    logic                   tag1_val, tag1_win;
    logic [POS_W-1:0]       tag1_pos, tag2_pos, tag3_pos;
    logic [CH_W-1:0]        tag1_ch, tag2_ch, tag3_ch;
    logic                   mac_in_val, mac_val, pipe_busy, inflight;
    logic signed [SUM_W-1:0]     mac_sum;
    logic signed [ACC_WIDTH-1:0] sum_ext, acc_rd, result, out_res;
    logic signed [ACC_WIDTH-1:0] acc_buf [NWIN];
    logic                   is_first, is_last;

    assign ff_rd_req = ((state == ST_RUN)   && (ff_data_counter >= CNT_WIN))
                    || ((state == ST_FLUSH) && (ff_data_counter >= CNT_ONE));
    assign busy      = (state != ST_IDLE);
    assign inflight  = tag1_val | pipe_busy;
    assign done      = (state == ST_DRAIN) && !inflight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ch_cnt  <= '0;
            pos_cnt <= '0;
            fl_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state   <= ST_RUN;
                    ch_cnt  <= '0;
                    pos_cnt <= '0;
                end
                ST_RUN: if (ff_rd_req) begin
                    if (pos_cnt == POS_LAST) begin
                        state  <= ST_FLUSH;
                        fl_cnt <= '0;
                    end else begin
                        pos_cnt <= pos_cnt + 1'b1;
                    end
                end
                ST_FLUSH: if (ff_rd_req) begin
                    if (fl_cnt == FL_LAST) begin
                        if (ch_cnt != CH_LAST) begin
                            ch_cnt  <= ch_cnt + 1'b1;
                            pos_cnt <= '0;
                            state   <= ST_RUN;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else begin
                        fl_cnt <= fl_cnt + 1'b1;
                    end
                end
                default: if (!inflight) begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                wgt[k] <= '0;
            end
        end else if (state == ST_IDLE && wgt_wr) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (wgt_idx == 2'(k)) begin
                    wgt[k] <= wgt_data;
                end
            end
        end
    end

    always_comb begin
        wgt_flat = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            wgt_flat[k*DAT_WIDTH +: DAT_WIDTH] = wgt[k];
        end
    end

    // Tags ride alongside the window so counters may already belong to the next row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag1_val <= 1'b0;
            tag1_win <= 1'b0;
            tag1_pos <= '0;
            tag1_ch  <= '0;
            tag2_pos <= '0;
            tag2_ch  <= '0;
            tag3_pos <= '0;
            tag3_ch  <= '0;
        end else begin
            tag1_val <= ff_rd_req;
            if (ff_rd_req) begin
                tag1_win <= (state == ST_RUN);
                tag1_pos <= pos_cnt;
                tag1_ch  <= ch_cnt;
            end
            if (mac_in_val) begin
                tag2_pos <= tag1_pos;
                tag2_ch  <= tag1_ch;
            end
            tag3_pos <= tag2_pos;
            tag3_ch  <= tag2_ch;
        end
    end

    assign mac_in_val = ff_rd_data_val & tag1_val & tag1_win;

    mac3 #(
        .DAT_WIDTH (DAT_WIDTH),
        .SUM_WIDTH (SUM_W)
    ) u_mac3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_val    (mac_in_val),
        .pix       (ff_rd_data),
        .wgt       (wgt_flat),
        .out_val   (mac_val),
        .out_sum   (mac_sum),
        .pipe_busy (pipe_busy)
    );

    assign sum_ext  = ACC_WIDTH'(mac_sum);
    assign acc_rd   = acc_buf[tag3_pos];
    assign is_first = (tag3_ch == '0);
    assign is_last  = (tag3_ch == CH_LAST);
    assign result   = is_first ? sum_ext : acc_rd + sum_ext;

    always_ff @(posedge clk) begin
        if (mac_val && !is_last) begin
            acc_buf[tag3_pos] <= result;
        end
    end

`ifdef CONV1X3_RELU_EN
    assign out_res = result[ACC_WIDTH-1] ? '0 : result;
`else
    assign out_res = result;
`endif

    assign out_val  = mac_val & is_last;
    assign out_data = out_val ? out_res : '0;

endmodule

// File: tb/tb_conv1x3_row_engine.sv
// tb/tb_conv1x3_row_engine.sv - directed bench for conv1x3_row_engine with NUM_CH=1 and NUM_CH=4 instances
module tb_conv1x3_row_engine;

    logic        clk;
    logic        rst_n;
    logic [1:0]  start_v;
    logic        wgt_wr;
    logic [1:0]  wgt_idx;
    logic [7:0]  wgt_data;
    logic [3:0]  ff_cnt  [2];
    logic [23:0] ff_data [2];
    logic        ff_val  [2];
    logic        req     [2];
    logic [20:0] od      [2];
    logic        ov      [2];
    logic        bsy     [2];
    logic        dn      [2];

    int n_err = 0;
    int n_chk = 0;
    int q   [2][$];
    int src [2][$];
    int got [2][$];
    int pops[2], low_pops[2], first_pop[2], last_pop[2], first_pops[2];
    int done_n[2], done_cyc[2], last_out[2], tick[2];
    int cyc = 0;
    bit trickle = 0;
    logic [1:0] req_s;

    conv1x3_row_engine #(.NUM_CH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .wgt_wr(wgt_wr), .wgt_idx(wgt_idx),
        .wgt_data(wgt_data), .ff_data_counter(ff_cnt[0]), .ff_rd_req(req[0]),
        .ff_rd_data(ff_data[0]), .ff_rd_data_val(ff_val[0]), .out_data(od[0]),
        .out_val(ov[0]), .busy(bsy[0]), .done(dn[0])
    );

    conv1x3_row_engine #(.NUM_CH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .wgt_wr(wgt_wr), .wgt_idx(wgt_idx),
        .wgt_data(wgt_data), .ff_data_counter(ff_cnt[1]), .ff_rd_req(req[1]),
        .ff_rd_data(ff_data[1]), .ff_rd_data_val(ff_val[1]), .out_data(od[1]),
        .out_val(ov[1]), .busy(bsy[1]), .done(dn[1])
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Registered-count FIFO model: a pop at an edge returns its window one cycle later.
    always @(posedge clk) begin
        req_s = {req[1], req[0]};
        #1;
        for (int i = 0; i < 2; i++) begin
            if (req_s[i]) begin
                for (int k = 0; k < 3; k++) begin
                    ff_data[i][k*8 +: 8] = (k < q[i].size()) ? 8'(q[i][k]) : 8'd0;
                end
                ff_val[i] = 1'b1;
                if (pops[i] == 0) first_pop[i] = cyc;
                last_pop[i] = cyc;
                pops[i]++;
                if (ff_cnt[i] < 4'd3) low_pops[i]++;
                if (q[i].size() > 0) void'(q[i].pop_front());
            end else begin
                ff_val[i] = 1'b0;
            end
            if (trickle) begin
                if (tick[i] % 4 == 0 && src[i].size() > 0 && q[i].size() < 8)
                    q[i].push_back(src[i].pop_front());
                tick[i]++;
            end else begin
                while (q[i].size() < 8 && src[i].size() > 0)
                    q[i].push_back(src[i].pop_front());
            end
            ff_cnt[i] = 4'(q[i].size());
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (ov[i]) begin
                got[i].push_back(int'($signed(od[i])));
                last_out[i] = cyc;
                if (got[i].size() == 1) first_pops[i] = pops[i];
            end
            if (dn[i]) begin
                done_n[i]++;
                done_cyc[i] = cyc;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pix(input int mode, input int k);
        if (mode == 0) return 10 * (k + 1);
        if (mode == 1) return 255;
        return k + 1;
    endfunction

    task automatic set_w(input int w0, input int w1, input int w2);
        int w[3];
        w = '{w0, w1, w2};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wgt_wr = 1'b1; wgt_idx = 2'(k); wgt_data = 8'(w[k]);
        end
        @(negedge clk);
        wgt_wr = 1'b0;
    endtask

    task automatic clear_mon();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            got[i].delete();
            pops[i] = 0; low_pops[i] = 0; first_pops[i] = 0; done_n[i] = 0; tick[i] = 0;
        end
    endtask

    task automatic load(input int d, input int rows, input int mode);
        for (int r = 0; r < rows; r++)
            for (int k = 0; k < 8; k++)
                src[d].push_back(pix(mode, k));
        @(negedge clk);
    endtask

    task automatic go(input int d);
        @(negedge clk);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input string tag);
        int c = 0;
        while (done_n[d] == 0 && c < 800) begin
            @(negedge clk);
            c++;
        end
        chk(tag, int'(done_n[d] != 0), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_outs(input int d, input string tag, input int n, input int exp);
        chk({tag, "_count"}, got[d].size(), n);
        for (int k = 0; k < got[d].size() && k < n; k++)
            chk({tag, "_val"}, got[d][k], exp);
    endtask

    initial begin
        rst_n = 0; start_v = '0; wgt_wr = 0; wgt_idx = 0; wgt_data = 0;
        for (int i = 0; i < 2; i++) begin
            ff_cnt[i] = '0; ff_data[i] = '0; ff_val[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_req",  int'(req[0]), 0);
        chk("rst_oval", int'(ov[0]),  0);
        chk("rst_odat", int'(od[0]),  0);
        chk("rst_busy", int'(bsy[0]), 0);
        chk("rst_done", int'(dn[1]),  0);
        rst_n = 1;

        set_w(1, 0, -1);
        clear_mon();
        load(0, 1, 0);
        go(0);
        wait_done(0, "t1_done");
        chk_outs(0, "t1", 6, -20);
        chk("t1_pops", pops[0], 8);
        chk("t1_span", last_pop[0] - first_pop[0], 7);
        chk("t1_low_pops", low_pops[0], 2);
        chk("t1_done_lat", done_cyc[0] - last_out[0], 1);
        chk("t1_idle", int'(bsy[0]), 0);

        set_w(1, 1, 1);
        clear_mon();
        load(1, 4, 1);
        go(1);
        wait_done(1, "t2_done");
        chk_outs(1, "t2", 6, 3060);
        chk("t2_ch3_only", int'(first_pops[1] >= 25), 1);

        set_w(1, 0, -1);
        clear_mon();
        trickle = 1;
        load(0, 1, 0);
        go(0);
        wait_done(0, "t3_done");
        chk_outs(0, "t3", 6, -20);
        chk("t3_pops", pops[0], 8);
        chk("t3_low_pops", low_pops[0], 2);
        trickle = 0;

        set_w(-128, -128, -128);
        clear_mon();
        load(0, 1, 1);
        go(0);
        wait_done(0, "t4_done");
`ifdef CONV1X3_RELU_EN
        chk_outs(0, "t4_relu", 6, 0);
`else
        chk_outs(0, "t4_raw", 6, -97920);
`endif

        set_w(1, 1, 1);
        clear_mon();
        load(1, 4, 2);
        go(1);
        repeat (5) @(negedge clk);
        start_v[1] = 1'b1; wgt_wr = 1'b1; wgt_idx = 2'd0; wgt_data = 8'd5;
        @(negedge clk);
        start_v[1] = 1'b0; wgt_wr = 1'b0;
        wait_done(1, "t5_done");
        chk("t5_count", got[1].size(), 6);
        for (int k = 0; k < got[1].size() && k < 6; k++)
            chk("t5_val", got[1][k], 4 * (3 * k + 6));
        repeat (5) @(negedge clk);
        chk("t5_one_done", done_n[1], 1);
        chk("t5_idle", int'(bsy[1]), 0);

        clear_mon();
        load(1, 4, 1);
        go(1);
        for (int c = 0; c < 400 && got[1].size() < 3; c++) @(negedge clk);
        chk("t6_three_out", int'(got[1].size() >= 3), 1);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_oval", int'(ov[1]),  0);
        chk("t6_rst_odat", int'(od[1]),  0);
        chk("t6_rst_busy", int'(bsy[1]), 0);
        chk("t6_rst_req",  int'(req[1]), 0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            q[i].delete();
            src[i].delete();
        end
        @(negedge clk);
        rst_n = 1;

        clear_mon();
        load(0, 1, 1);
        go(0);
        wait_done(0, "t7_done");
        chk_outs(0, "t7_wgt_rst", 6, 0);

        set_w(1, 1, 1);
        clear_mon();
        load(1, 4, 1);
        go(1);
        wait_done(1, "t8_done");
        chk_outs(1, "t8_rerun", 6, 3060);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/conv1x3_row_engine.md
# conv1x3_row_engine

- Downstream consumer of the 3-wide pop-1 FIFO, which presents 3 consecutive pixels per pop.
- Issues pops to the FIFO based on its occupancy count.
- Multiplies each 3-pixel window by 3 stored signed weights.
- Accumulates the sums over NUM_CH input-channel rows in a per-position accumulator buffer, and emits one output row of ROW_LEN-2 values on a valid-only stream.

## Interface
- DAT_WIDTH, 8: pixel and weight width.
- NUM_RDATA, 3: window taps; fixed at 3.
- FF_ADDR_WIDTH, 3: FIFO address width; the occupancy input is FF_ADDR_WIDTH+1 bits.
- ROW_LEN, 8: pixels per input row, at least 3; yields ROW_LEN-2 windows per row.
- NUM_CH, 4: channel rows accumulated per output row, at least 1.
- ACC_WIDTH, 21: accumulator/output width; must be at least 2*DAT_WIDTH+3+clog2(NUM_CH).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- wgt_wr  in  1  weight write strobe; honoured only in IDLE.
- wgt_idx  in  2  tap index 0..2; value 3 is ignored.
- wgt_data  in  DAT_WIDTH  signed weight.
- ff_data_counter  in  FF_ADDR_WIDTH+1  FIFO occupancy.
- ff_rd_req  out  1  FIFO pop request.
- ff_rd_data  in  DAT_WIDTH*3  window; tap0 = [DAT_WIDTH-1:0] (oldest pixel).
- ff_rd_data_val  in  1  window valid, one cycle after the pop.
- out_data  out  ACC_WIDTH  signed result.
- out_val  out  1  result valid; there is no backpressure.
- busy  out  1  high whenever not in IDLE.
- done  out  1  one-cycle pulse after the last out_val.

## Operation
- Pixels are unsigned; weights are two's-complement.
- Window sum = Σ w[k]*p[k], sign-extended to ACC_WIDTH. The width rule guarantees no overflow, so arithmetic wraps and never saturates.
- States:
  - IDLE
  - RUN: pop windows
  - FLUSH: discard the last 2 pixels of the row
  - DRAIN: wait for the pipeline to empty
- Transitions:
  - IDLE -> RUN on start. Clears ch_cnt and pos_cnt.
  - RUN: assert ff_rd_req in any cycle where ff_data_counter >= 3.
    - pos_cnt increments per pop.
    - After pop ROW_LEN-2, go to FLUSH.
  - FLUSH: assert ff_rd_req when ff_data_counter >= 1, for exactly 2 pops.
    - The returned data is ignored and the accumulators are untouched.
    - Then, if ch_cnt < NUM_CH-1: increment ch_cnt, clear pos_cnt, go to RUN.
    - Otherwise go to DRAIN.
  - DRAIN -> IDLE when no window remains in flight. done pulses in that cycle.
- Accumulator buffer: ROW_LEN-2 entries of ACC_WIDTH, indexed by window position.
  - Channel 0 writes the window sum directly; no clear pass is needed.
  - Channels 1..NUM_CH-2 add the window sum into the entry.
  - Channel NUM_CH-1 drives entry + sum onto out_data with out_val=1, and does not write back.
  - If NUM_CH=1, channel 0 drives the sum straight to the output.
- The position and channel tags travel with the pipeline, not with the counters.
- A start pulse while busy is ignored. A wgt_wr while busy is ignored.
- Weights hold their value across runs and reset to 0.

## Timing
- Pop at cycle t, ff_rd_data_val at t+1, product register at t+2, sum/accumulate at t+3. out_val is at t+3.
- Throughput is one window per cycle while ff_data_counter >= 3.
- The occupancy input is registered in the FIFO, so back-to-back pops stop exactly when the count drops below 3; no extra in-flight compensation is needed.
- The pipeline advances only on ff_rd_data_val.
- Reset values:
  - ff_rd_req=0, out_val=0, out_data=0, busy=0, done=0.
  - State = IDLE, all counters 0, weights 0.
  - Accumulator buffer contents are don't-care.
- Reset mid-run: all outputs go to their reset values immediately (asynchronous assertion). In-flight windows are dropped.
- Deassertion is synchronised externally.
- Simultaneous start and wgt_wr in IDLE: the weight write takes effect, and the new weight is used by the run.

## Configuration
- CONV1X3_RELU_EN defined: every out_data value that would be negative is driven as 0. Latency is unchanged.
- Not defined: out_data is the raw signed sum.
- Intermediate accumulators are never clamped in either case.

## Structure
- Shared package conv_pkg holds:
  - the state typedef (IDLE/RUN/FLUSH/DRAIN)
  - the constant FLUSH_POPS = NUM_RDATA-1
  - a clog2-based minimum-ACC_WIDTH function, used by an elaboration-time width check.
- One natural sub-module: mac3. It contains the 3-tap unsigned×signed multiply stage plus the registered adder tree, and adds 2 cycles of latency.

## Test plan
- Weights {1,0,-1}, NUM_CH=1, row 10,20,…,80 pre-loaded:
  - ff_rd_req asserted for 6 back-to-back cycles, then 2 flush pops.
  - out_data = -20 six times, then done.
- Weights {1,1,1}, NUM_CH=4, every row all 255:
  - 6 outputs, each 3060, valid only during channel 3.
  - No out_val during channels 0–2.
- FIFO trickle, one pixel written every 4 cycles: pops occur only when count >= 3. The result sequence is identical to the pre-loaded case.
- Weights {-128,-128,-128}, pixels 255, CONV1X3_RELU_EN defined: out_data = 0. Undefined: out_data = -97920 (NUM_CH=1).
- start pulsed while busy, and wgt_wr to tap 0 = 5 while busy: both are ignored, and outputs match the original weights.
- rst_n asserted after the 3rd output of channel 3: out_val drops at once and state returns to IDLE. A new run after reset produces 6 correct outputs.
